// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate cache between the MEM stage
// and an SRAM controller. Lines hold two words and are filled with two SRAM reads.
module cache_controller #(
    parameter int unsigned SETS = 64,
    parameter logic [31:0] BASE = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_read,
    output logic        sram_write,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int unsigned IdxW = $clog2(SETS);
    localparam int unsigned TagW = 10;
    localparam int unsigned TagLsb = 3 + IdxW;

    typedef enum logic [1:0] {
        StIdle,
        StFillLo,
        StFillHi,
        StWrite
    } state_e;

    state_e state_q, state_d;

    logic [SETS-1:0] valid_q [2];
    logic [SETS-1:0] lru_q;
    logic [TagW-1:0] tag_q   [2][SETS];
    logic [63:0]     data_q  [2][SETS];

    logic [31:0]     fill_lo_q, fill_lo_d;

    logic [31:0]     a;
    logic            word_sel;
    logic [IdxW-1:0] idx;
    logic [TagW-1:0] tag;
    logic            unused_addr_bits;

    logic            hit0, hit1, hit, hit_way;
    logic [63:0]     hit_line;
    logic [31:0]     hit_word;
    logic            victim;

    logic            hit_touch;
    logic            fill_en;
    logic            inval_en;

    assign a        = address - BASE;
    assign word_sel = a[2];
    assign idx      = a[3 +: IdxW];
    assign tag      = a[TagLsb +: TagW];
    assign unused_addr_bits = ^{a[1:0], a[31:TagLsb+TagW]};

    assign hit0     = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit1     = valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign hit      = hit0 || hit1;
    assign hit_way  = hit1;
    assign hit_line = hit1 ? data_q[1][idx] : data_q[0][idx];
    assign hit_word = word_sel ? hit_line[63:32] : hit_line[31:0];
    assign victim   = lru_q[idx];

    assign sram_wdata = wdata;

    always_comb begin
        state_d      = state_q;
        fill_lo_d    = fill_lo_q;
        ready        = 1'b0;
        rdata        = '0;
        sram_read    = 1'b0;
        sram_write   = 1'b0;
        sram_address = {address[31:2], 2'b00};
        hit_touch    = 1'b0;
        fill_en      = 1'b0;
        inval_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Stores win over loads when both enables are raised together.
                if (MEM_W_EN) begin
                    state_d = StWrite;
                end else if (MEM_R_EN) begin
                    if (hit) begin
                        ready     = 1'b1;
                        rdata     = hit_word;
                        hit_touch = 1'b1;
                    end else begin
                        state_d = StFillLo;
                    end
                end else begin
                    ready = 1'b1;
                end
            end

            StFillLo: begin
                sram_read    = 1'b1;
                sram_address = {address[31:3], 3'b000};
                if (sram_ready) begin
                    fill_lo_d = sram_rdata;
                    state_d   = StFillHi;
                end
            end

            StFillHi: begin
                sram_read    = 1'b1;
                sram_address = {address[31:3], 3'b100};
                if (sram_ready) begin
                    fill_en = 1'b1;
                    ready   = 1'b1;
                    state_d = StIdle;
                    if (MEM_R_EN) begin
                        rdata = word_sel ? sram_rdata : fill_lo_q;
                    end
                end
            end

            StWrite: begin
                sram_write   = 1'b1;
                sram_address = {address[31:2], 2'b00};
                if (sram_ready) begin
                    ready    = 1'b1;
                    inval_en = hit;
                    state_d  = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            fill_lo_q  <= '0;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            state_q   <= state_d;
            fill_lo_q <= fill_lo_d;
            if (hit_touch) begin
                lru_q[idx] <= ~hit_way;
            end
            if (fill_en) begin
                valid_q[victim][idx] <= 1'b1;
                lru_q[idx]           <= ~victim;
            end
            if (inval_en) begin
                if (hit0) valid_q[0][idx] <= 1'b0;
                if (hit1) valid_q[1][idx] <= 1'b0;
            end
        end
    end

    // Tags and line data carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[victim][idx]  <= tag;
            data_q[victim][idx] <= {sram_rdata, fill_lo_q};
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural SRAM of programmable latency.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_read;
    logic        sram_write;
    logic [31:0] sram_rdata;
    logic        sram_ready;

    cache_controller #(
        .SETS(64),
        .BASE(32'd1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .wdata       (wdata),
        .MEM_R_EN    (MEM_R_EN),
        .MEM_W_EN    (MEM_W_EN),
        .rdata       (rdata),
        .ready       (ready),
        .sram_address(sram_address),
        .sram_wdata  (sram_wdata),
        .sram_read   (sram_read),
        .sram_write  (sram_write),
        .sram_rdata  (sram_rdata),
        .sram_ready  (sram_ready)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    int          lat = 0;
    int          cnt = 0;
    int          cnt_nx = 0;
    int          n_reads = 0;
    int          n_writes = 0;
    int          n_both = 0;
    int          n_unstable = 0;
    logic [31:0] rd_addrs [$];
    logic [31:0] last_wdata = '0;
    logic [31:0] last_waddr = '0;
    logic [31:0] prev_addr = '0;
    logic        prev_rd = 1'b0;

    int n_tests = 0;
    int n_fail = 0;

    assign sram_ready = (sram_read || sram_write) && (cnt == lat);
    assign sram_rdata = mem[sram_address[11:2]];

    // SRAM model and bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cnt_nx <= ((sram_read || sram_write) && !sram_ready) ? cnt + 1 : 0;
        if (sram_read && sram_ready) begin
            n_reads++;
            rd_addrs.push_back(sram_address);
        end
        if (sram_write && sram_ready) begin
            n_writes++;
            last_wdata = sram_wdata;
            last_waddr = sram_address;
            mem[sram_address[11:2]] = sram_wdata;
        end
        if (sram_read && sram_write) n_both++;
        if ((sram_read || sram_write) && cnt > 0 &&
            (sram_address != prev_addr || sram_read != prev_rd)) n_unstable++;
        prev_addr = sram_address;
        prev_rd   = sram_read;
    end

    always @(posedge clk) cnt <= cnt_nx;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request, hold it until ready, return rdata and the cycles spent waiting.
    task automatic access(input logic r, input logic w, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] data, output int cyc);
        address  = addr;
        wdata    = wd;
        MEM_R_EN = r;
        MEM_W_EN = w;
        cyc      = 0;
        #1;
        while (!ready && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        data = rdata;
        if (!ready) check_eq("timeout", {31'b0, ready}, 32'd1);
        @(posedge clk);
        #1;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
    endtask

    logic [31:0] d;
    int          cyc;
    int          r0, w0;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
        mem[256] = 32'hA5A5_A5A5;
        mem[257] = 32'h1234_5678;
        rst = 1'b1; address = '0; wdata = '0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("rst_ready", {31'b0, ready}, 32'd1);
        check_eq("rst_sram_read", {31'b0, sram_read}, 32'd0);
        check_eq("rst_sram_write", {31'b0, sram_write}, 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        @(posedge clk);
        #1;

        // Cold load
        rd_addrs.delete();
        r0 = n_reads;
        access(1'b1, 1'b0, 32'd1024, '0, d, cyc);
        check_eq("cold_data", d, 32'hA5A5_A5A5);
        check_eq("cold_cycles", cyc, 32'd2);
        check_eq("cold_reads", n_reads - r0, 32'd2);
        check_eq("cold_addr0", rd_addrs[0], 32'd1024);
        check_eq("cold_addr1", rd_addrs[1], 32'd1028);
        r0 = n_reads;
        access(1'b1, 1'b0, 32'd1028, '0, d, cyc);
        check_eq("hit1028_cycles", cyc, 32'd0);
        check_eq("hit1028_data", d, 32'h1234_5678);
        check_eq("hit1028_reads", n_reads - r0, 32'd0);

        // LRU: three tags in set 0
        access(1'b1, 1'b0, 32'd1536, '0, d, cyc);
        check_eq("lru_1536_data", d, 32'h1000_0180);
        access(1'b1, 1'b0, 32'd2048, '0, d, cyc);
        check_eq("lru_2048_data", d, 32'h1000_0200);
        check_eq("lru_2048_cycles", cyc, 32'd2);
        access(1'b1, 1'b0, 32'd1536, '0, d, cyc);
        check_eq("lru_1536_rehit", cyc, 32'd0);
        access(1'b1, 1'b0, 32'd1024, '0, d, cyc);
        check_eq("lru_1024_evicted", cyc, 32'd2);
        check_eq("lru_1024_data", d, 32'hA5A5_A5A5);

        // Write invalidate
        access(1'b1, 1'b0, 32'd1024, '0, d, cyc);
        check_eq("wi_prehit", cyc, 32'd0);
        w0 = n_writes;
        access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, d, cyc);
        check_eq("wi_cycles", cyc, 32'd1);
        check_eq("wi_writes", n_writes - w0, 32'd1);
        check_eq("wi_wdata", last_wdata, 32'hDEAD_BEEF);
        check_eq("wi_waddr", last_waddr, 32'd1024);
        access(1'b1, 1'b0, 32'd1024, '0, d, cyc);
        check_eq("wi_reload_miss", cyc, 32'd2);
        check_eq("wi_reload_data", d, 32'hDEAD_BEEF);

        // Both enables: write only
        r0 = n_reads;
        w0 = n_writes;
        access(1'b1, 1'b1, 32'd1024, 32'hCAFE_F00D, d, cyc);
        check_eq("both_reads", n_reads - r0, 32'd0);
        check_eq("both_writes", n_writes - w0, 32'd1);

        // Slow SRAM
        lat = 5;
        r0 = n_reads;
        access(1'b1, 1'b0, 32'd1032, '0, d, cyc);
        check_eq("slow_cycles", cyc, 32'd12);
        check_eq("slow_reads", n_reads - r0, 32'd2);
        check_eq("slow_data", d, 32'h1000_0102);
        check_eq("slow_stable", n_unstable, 32'd0);

        // Reset while in the second fill access
        address  = 32'd1040;
        MEM_R_EN = 1'b1;
        begin
            int k = 0;
            while (!(sram_read && sram_address[2]) && k < 100) begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        check_eq("mf_fill_hi_addr", sram_address, 32'd1044);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        MEM_R_EN = 1'b0;
        #1;
        check_eq("mf_sram_read", {31'b0, sram_read}, 32'd0);
        check_eq("mf_ready", {31'b0, ready}, 32'd1);
        check_eq("mf_rdata", rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        lat = 0;
        @(posedge clk);
        #1;
        r0 = n_reads;
        access(1'b1, 1'b0, 32'd1040, '0, d, cyc);
        check_eq("mf_reload_miss", cyc, 32'd2);
        check_eq("mf_reload_reads", n_reads - r0, 32'd2);
        check_eq("mf_reload_data", d, 32'h1000_0104);

        check_eq("never_rd_and_wr", n_both, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameters: SETS=64 (cache sets); BASE=32'd1024 (memory base address subtracted from every address).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 address  input  32  byte address from the MEM stage.
REQ-005 wdata  input  32  store data.
REQ-006 MEM_R_EN  input  1  load request, held until ready=1.
REQ-007 MEM_W_EN  input  1  store request, held until ready=1.
REQ-008 rdata  output  32  load result; valid when ready=1 with MEM_R_EN=1.
REQ-009 ready  output  1  0 stalls the pipeline.
REQ-010 sram_address  output  32  word-aligned byte address to the SRAM controller, BASE not removed.
REQ-011 sram_wdata  output  32  store data to the SRAM controller.
REQ-012 sram_read  output  1  SRAM read enable.
REQ-013 sram_write  output  1  SRAM write enable.
REQ-014 sram_rdata  input  32  SRAM read data; valid in the cycle sram_ready=1.
REQ-015 sram_ready  input  1  SRAM access complete; sampled only while sram_read or sram_write=1.

Function
REQ-016 Address split, with a = address-BASE:
- a[2] = word select within a 2-word line.
- a[8:3] = set index.
- a[18:9] = 10-bit tag.
- a[1:0] and a[31:19] are ignored.
REQ-017 Storage, 2-way set-associative; per set and way: valid bit, 10-bit tag, 64-bit line. Per set: one LRU bit naming the least-recently-used way.
REQ-018 Hit = valid and tag match in either way; both ways never hold the same tag for one set.
REQ-019 FSM states: IDLE, FILL_LO, FILL_HI, WRITE.
REQ-020 IDLE, no request: ready=1 and sram_read=sram_write=0.
REQ-021 IDLE, MEM_W_EN=1: go to WRITE. MEM_W_EN has priority when both enables are high.
REQ-022 IDLE, MEM_R_EN=1, hit:
- rdata = selected word of the hit way, combinationally in the same cycle.
- ready=1 in that same cycle.
- LRU bit set to the other way at the clock edge.
- State stays IDLE; zero-cycle latency.
REQ-023 IDLE, MEM_R_EN=1, miss: ready=0 and go to FILL_LO.
REQ-024 FILL_LO:
- sram_read=1, sram_address = {address[31:3],3'b000}.
- On sram_ready=1, capture sram_rdata as the low word and go to FILL_HI.
REQ-025 FILL_HI:
- sram_read=1, sram_address = {address[31:3],3'b100}.
- On sram_ready=1, write {sram_rdata, low word} into the way named by LRU, set its valid bit and tag, set LRU to the other way, and go to IDLE.
REQ-026 FILL_HI completion cycle: ready=1 combinationally; rdata = low word if a[2]=0, else sram_rdata.
REQ-027 A read miss therefore costs exactly two SRAM accesses. sram_read stays high continuously from FILL_LO entry until FILL_HI completion.
REQ-028 WRITE (write-through, no write-allocate):
- sram_write=1, sram_address = {address[31:2],2'b00}, sram_wdata=wdata.
- On sram_ready=1: ready=1, go to IDLE, and clear the valid bit of the matching way if the address hit.
REQ-029 ready=0 in FILL_LO, in WRITE before sram_ready, and in FILL_HI before sram_ready.
REQ-030 sram_read and sram_write are never both 1.
REQ-031 Both enables dropping mid-access (protocol violation): the SRAM access in progress still completes; the line is still filled.
REQ-032 Same address requested on the cycle after a fill or a write: it hits, or misses after invalidation, respectively.

Reset
REQ-033 rst=1 at any time, including mid-fill or mid-write, forces state IDLE.
REQ-034 rst=1 also clears all valid bits and all LRU bits to 0, and drives sram_read=sram_write=0 immediately.
REQ-035 Line data and tags are not reset.
REQ-036 After reset: ready=1 (with no request pending) and rdata=0 when no load is active.

Verification
REQ-037 Cold load: after reset, MEM_R_EN at 1024 (SRAM word0=0xA5A5A5A5, word1=0x12345678).
- Exactly two sram_read accesses occur, at addresses 1024 then 1028.
- ready=1 with rdata=0xA5A5A5A5.
- A repeat load of 1028 hits in 0 cycles, rdata=0x12345678.
REQ-038 LRU: loads to 1024, 1024+512, 1024+1024 (same set, distinct tags).
- The third access evicts the 1024 line.
- A reload of 1024+512 hits; a reload of 1024 misses.
REQ-039 Write invalidate: load 1024 (hit established), then store 0xDEADBEEF to 1024.
- One sram_write occurs with sram_wdata=0xDEADBEEF.
- A following load of 1024 misses and returns 0xDEADBEEF.
REQ-040 Simultaneous MEM_R_EN=MEM_W_EN=1 at 1024: only a write sequence occurs; no sram_read is issued.
REQ-041 Reset mid-fill: rst asserted in FILL_HI.
- Next cycle: state IDLE, sram_read=0, ready=1.
- A load of the same address misses again.
REQ-042 Slow SRAM: sram_ready delayed 5 cycles per access.
- ready stays 0 for the full miss sequence.
- sram_read and sram_address remain stable throughout each access.
